// File: rtl/hit_resolver.sv
// hit_resolver: judges attack contact between two players, issues one-cycle
// hit/block pulses, runs a stun timer per player and a RUN/KO/DONE round FSM.
//
// Optional feature macro: HIT_RESOLVER_TRADE_EN
//   defined   -> simultaneous contacts (a trade) both resolve in the same cycle
//   undefined -> a trade is a clash: no pulses, no stun, both spent latches set
//
// Player indexing inside this file: index 0 is P1, index 1 is P2. For the
// per-player generate block, gi is the player in its own role; as an attacker
// it strikes player OPP, and as a defender it is struck by player OPP.
module hit_resolver #(
  parameter int HITSTUN_CYCLES   = 24,
  parameter int BLOCKSTUN_CYCLES = 12,
  parameter int KO_HOLD_CYCLES   = 60,
  parameter int CW               = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       p1_attack_active,
  input  logic       p2_attack_active,
  input  logic       p1_overlap,
  input  logic       p2_overlap,
  input  logic       p1_blocking,
  input  logic       p2_blocking,
  input  logic [2:0] p1_block_left,
  input  logic [2:0] p2_block_left,
  input  logic [2:0] p1_health,
  input  logic [2:0] p2_health,
  input  logic       round_restart,
  output logic       p1_hit,
  output logic       p2_hit,
  output logic       p1_block,
  output logic       p2_block,
  output logic       p1_stun,
  output logic       p2_stun,
  output logic       ko,
  output logic [1:0] winner,
  output logic       round_done
);

  // Round FSM encoding
  localparam logic [1:0] ST_RUN  = 2'd0;
  localparam logic [1:0] ST_KO   = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Counter load values, sized to the counter width
  localparam logic [CW-1:0] HIT_LOAD   = CW'(HITSTUN_CYCLES);
  localparam logic [CW-1:0] BLOCK_LOAD = CW'(BLOCKSTUN_CYCLES);
  localparam logic [CW-1:0] HOLD_LOAD  = CW'(KO_HOLD_CYCLES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  // Per-player views of the inputs
  logic [1:0] attack_active;
  logic [1:0] overlap;
  logic [1:0] blocking;
  logic [2:0] block_left [2];
  logic [2:0] health     [2];

  assign attack_active = {p2_attack_active, p1_attack_active};
  assign overlap       = {p2_overlap, p1_overlap};
  assign blocking      = {p2_blocking, p1_blocking};
  assign block_left[0] = p1_block_left;
  assign block_left[1] = p2_block_left;
  assign health[0]     = p1_health;
  assign health[1]     = p2_health;

  // Round FSM state
  logic [1:0]    state_reg, state_next;
  logic [CW-1:0] hold_reg, hold_next;
  logic [1:0]    winner_reg, winner_next;
  logic          ko_reg;
  logic          round_done_reg;

  // Per-player flags collected from the generate block
  logic [1:0] stun_vec;    // player is currently stunned
  logic [1:0] hit_vec;     // player took a clean hit last edge
  logic [1:0] block_vec;   // player blocked last edge
  logic [1:0] contact;     // player, as attacker, has a valid contact this cycle
  logic [1:0] resolve;     // player's contact actually lands this cycle

  logic in_run;
  logic restart;

  assign in_run  = (state_reg == ST_RUN);
  assign restart = (state_reg == ST_DONE) && round_restart;

  // Per-player attack, defence and stun logic
  for (genvar gi = 0; gi < 2; gi++) begin : g_player
    localparam int OPP = 1 - gi;

    logic          spent_reg;
    logic [CW-1:0] stun_timer_reg;
    logic [CW-1:0] stun_timer_next;
    logic          stun_reg;
    logic          hit_reg;
    logic          block_reg;
    logic          guard_ok;
    logic          struck;

    // Contact needs a fresh live attack on an unstunned opponent while
    // the attacker itself is free to act and the round is running.
    assign contact[gi] = attack_active[gi] & overlap[gi] & ~spent_reg &
                         ~stun_vec[OPP] & ~stun_vec[gi] & in_run;

`ifdef HIT_RESOLVER_TRADE_EN
    assign resolve[gi] = contact[gi];
`else
    assign resolve[gi] = contact[gi] & ~contact[OPP];
`endif

    // Defender side: a guard only holds while blocks remain
    assign struck   = resolve[OPP];
    assign guard_ok = blocking[gi] & (block_left[gi] != 3'd0);

    // Stun timer next value: restart clears, a landed strike loads, else count down to 0
    always_comb begin
      stun_timer_next = stun_timer_reg;
      if (restart) begin
        stun_timer_next = '0;
      end else if (struck) begin
        stun_timer_next = guard_ok ? BLOCK_LOAD : HIT_LOAD;
      end else if (stun_timer_reg != '0) begin
        stun_timer_next = stun_timer_reg - CNT_ONE;
      end
    end

    // Spent latch: one event per attack; a clash also consumes the attack
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        spent_reg <= 1'b0;
      end else if (restart) begin
        spent_reg <= 1'b0;
      end else if (contact[gi]) begin
        spent_reg <= 1'b1;
      end else if (!attack_active[gi]) begin
        spent_reg <= 1'b0;
      end
    end

    // Stun timer, registered stun flag and event pulses for this defender
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        stun_timer_reg <= '0;
        stun_reg       <= 1'b0;
        hit_reg        <= 1'b0;
        block_reg      <= 1'b0;
      end else begin
        stun_timer_reg <= stun_timer_next;
        stun_reg       <= (stun_timer_next != '0);
        hit_reg        <= struck & ~guard_ok;
        block_reg      <= struck & guard_ok;
      end
    end

    assign stun_vec[gi]  = stun_reg;
    assign hit_vec[gi]   = hit_reg;
    assign block_vec[gi] = block_reg;
  end

  // Round FSM next-state: RUN -> KO on any zero health, KO holds, DONE waits for restart
  always_comb begin
    state_next  = state_reg;
    hold_next   = hold_reg;
    winner_next = winner_reg;
    case (state_reg)
      ST_RUN: begin
        if ((health[0] == 3'd0) || (health[1] == 3'd0)) begin
          state_next  = ST_KO;
          hold_next   = HOLD_LOAD;
          // Bit 1 = P2 wins (P1 down), bit 0 = P1 wins (P2 down); both = double KO
          winner_next = {health[0] == 3'd0, health[1] == 3'd0};
        end
      end
      ST_KO: begin
        // The transition happens on the edge that brings the counter to 0
        if (hold_reg <= CNT_ONE) begin
          state_next = ST_DONE;
          hold_next  = '0;
        end else begin
          hold_next = hold_reg - CNT_ONE;
        end
      end
      ST_DONE: begin
        if (round_restart) begin
          state_next  = ST_RUN;
          winner_next = 2'b00;
        end
      end
      default: begin
        state_next  = ST_RUN;
        hold_next   = '0;
        winner_next = 2'b00;
      end
    endcase
  end

  // Round FSM registers and registered round outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_RUN;
      hold_reg       <= '0;
      winner_reg     <= 2'b00;
      ko_reg         <= 1'b0;
      round_done_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      hold_reg       <= hold_next;
      winner_reg     <= winner_next;
      ko_reg         <= (state_next != ST_RUN);
      round_done_reg <= (state_next == ST_DONE);
    end
  end

  assign p1_hit     = hit_vec[0];
  assign p2_hit     = hit_vec[1];
  assign p1_block   = block_vec[0];
  assign p2_block   = block_vec[1];
  assign p1_stun    = stun_vec[0];
  assign p2_stun    = stun_vec[1];
  assign ko         = ko_reg;
  assign winner     = winner_reg;
  assign round_done = round_done_reg;

endmodule

// File: tb/tb_hit_resolver.sv
// Directed scoreboard bench for hit_resolver: every step pushes the output
// vector expected after the next clock edge, then pops and compares it.
// Vector layout: {p1_hit,p2_hit,p1_block,p2_block,p1_stun,p2_stun,ko,winner[1:0],round_done}
module tb_hit_resolver;

  localparam int HIT_N   = 24;
  localparam int BLOCK_N = 12;
  localparam int HOLD_N  = 60;

  logic       clk;
  logic       rst;
  logic       p1_attack_active, p2_attack_active;
  logic       p1_overlap, p2_overlap;
  logic       p1_blocking, p2_blocking;
  logic [2:0] p1_block_left, p2_block_left;
  logic [2:0] p1_health, p2_health;
  logic       round_restart;
  logic       p1_hit, p2_hit, p1_block, p2_block, p1_stun, p2_stun;
  logic       ko;
  logic [1:0] winner;
  logic       round_done;

  int n_checks = 0;
  int n_errors = 0;

  logic [9:0] exp_q[$];
  string      tag_q[$];
  logic [9:0] obs;

  assign obs = {p1_hit, p2_hit, p1_block, p2_block, p1_stun, p2_stun, ko, winner, round_done};

  hit_resolver #(
    .HITSTUN_CYCLES  (HIT_N),
    .BLOCKSTUN_CYCLES(BLOCK_N),
    .KO_HOLD_CYCLES  (HOLD_N),
    .CW              (8)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .p1_attack_active(p1_attack_active),
    .p2_attack_active(p2_attack_active),
    .p1_overlap      (p1_overlap),
    .p2_overlap      (p2_overlap),
    .p1_blocking     (p1_blocking),
    .p2_blocking     (p2_blocking),
    .p1_block_left   (p1_block_left),
    .p2_block_left   (p2_block_left),
    .p1_health       (p1_health),
    .p2_health       (p2_health),
    .round_restart   (round_restart),
    .p1_hit          (p1_hit),
    .p2_hit          (p2_hit),
    .p1_block        (p1_block),
    .p2_block        (p2_block),
    .p1_stun         (p1_stun),
    .p2_stun         (p2_stun),
    .ko              (ko),
    .winner          (winner),
    .round_done      (round_done)
  );

  always #5 clk = ~clk;

  function automatic logic [9:0] mk(input logic h1, input logic h2, input logic b1,
                                    input logic b2, input logic s1, input logic s2,
                                    input logic k, input logic [1:0] w, input logic rd);
    return {h1, h2, b1, b2, s1, s2, k, w, rd};
  endfunction

  // Pop the oldest expectation and compare it with the current outputs
  task automatic compare();
    logic [9:0] e;
    string      t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    n_checks++;
    assert (obs === e) else begin
      n_errors++;
      $error("FAIL %s: observed=%b expected=%b", t, obs, e);
    end
  endtask

  // Expectation for the outputs right now (used around async reset)
  task automatic check_now(input string tag, input logic [9:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    compare();
  endtask

  // Expectation for the cycle after the next rising edge
  task automatic step(input string tag, input logic [9:0] e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    compare();
  endtask

  logic [9:0] Z, S1, S2, HIT1, HIT2, BLK2, K01, D01, K11, TRD;

  initial begin
    Z    = mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 0);
    S1   = mk(0, 0, 0, 0, 1, 0, 0, 2'b00, 0);
    S2   = mk(0, 0, 0, 0, 0, 1, 0, 2'b00, 0);
    HIT1 = mk(1, 0, 0, 0, 1, 0, 0, 2'b00, 0);
    HIT2 = mk(0, 1, 0, 0, 0, 1, 0, 2'b00, 0);
    BLK2 = mk(0, 0, 0, 1, 0, 1, 0, 2'b00, 0);
    K01  = mk(0, 0, 0, 0, 0, 0, 1, 2'b01, 0);
    D01  = mk(0, 0, 0, 0, 0, 0, 1, 2'b01, 1);
    K11  = mk(0, 0, 0, 0, 0, 0, 1, 2'b11, 0);
    TRD  = mk(1, 1, 0, 0, 1, 1, 0, 2'b00, 0);

    clk = 0; rst = 1;
    p1_attack_active = 0; p2_attack_active = 0;
    p1_overlap = 0; p2_overlap = 0;
    p1_blocking = 0; p2_blocking = 0;
    p1_block_left = 3'd3; p2_block_left = 3'd3;
    p1_health = 3'd7; p2_health = 3'd7;
    round_restart = 0;

    // Reset state
    #2 rst = 0;
    #10 check_now("reset_state", Z);
    @(posedge clk); #1; rst = 1;
    step("idle", Z);

    // Clean hit: one pulse, 24 stun cycles, held overlap gives no repeat
    p1_attack_active = 1; p1_overlap = 1;
    step("hit_pulse", HIT2);
    repeat (HIT_N - 1) step("hit_stun", S2);
    repeat (40 - HIT_N) step("hit_no_repeat", Z);

    // Re-arm after stun end
    p1_attack_active = 0;
    step("rearm_drop", Z);
    p1_attack_active = 1;
    step("rearm_hit", HIT2);
    // Re-arm while defender stunned: overlap during stun is ignored,
    // contact lands as soon as stun reads 0
    repeat (3) step("rearm_stun", S2);
    p1_attack_active = 0;
    step("midstun_drop", S2);
    p1_attack_active = 1;
    repeat (HIT_N - 5) step("midstun_hold", S2);
    step("stun_reaches_zero", Z);
    step("hit_at_stun_zero", HIT2);
    repeat (HIT_N - 1) step("hit_stun2", S2);
    step("hit_stun2_end", Z);

    // Block with blocks left
    p1_attack_active = 0; p2_blocking = 1; p2_block_left = 3'd3;
    step("block_prep", Z);
    p1_attack_active = 1;
    step("block_pulse", BLK2);
    repeat (BLOCK_N - 1) step("block_stun", S2);
    step("block_stun_end", Z);

    // Block with no blocks left: guard broken, resolves as hit
    p1_attack_active = 0; p2_block_left = 3'd0;
    step("guard_prep", Z);
    p1_attack_active = 1;
    step("guard_broken_hit", HIT2);
    repeat (HIT_N - 1) step("guard_broken_stun", S2);
    step("guard_broken_end", Z);
    p1_attack_active = 0; p1_overlap = 0; p2_blocking = 0; p2_block_left = 3'd3;
    step("trade_prep", Z);

    // Trade: both attack and overlap in the same cycle
    p1_attack_active = 1; p1_overlap = 1; p2_attack_active = 1; p2_overlap = 1;
`ifdef HIT_RESOLVER_TRADE_EN
    step("trade_both_hit", TRD);
    repeat (HIT_N - 1) step("trade_both_stun", mk(0, 0, 0, 0, 1, 1, 0, 2'b00, 0));
    step("trade_stun_end", Z);
`else
    step("clash_no_pulse", Z);
    repeat (5) step("clash_spent", Z);
`endif
    p1_attack_active = 0; p1_overlap = 0; p2_attack_active = 0; p2_overlap = 0;
    step("trade_clear", Z);

    // KO on p2 health: P1 wins, contacts ignored, restart ignored while in KO
    p2_health = 3'd0;
    step("ko_enter", K01);
    p1_attack_active = 1; p1_overlap = 1;
    repeat (20) step("ko_hold", K01);
    round_restart = 1;
    step("ko_restart_ignored", K01);
    round_restart = 0;
    repeat (HOLD_N - 22) step("ko_hold2", K01);
    step("round_done", D01);
    step("done_hold", D01);
    p1_attack_active = 0; p1_overlap = 0; p2_health = 3'd7; round_restart = 1;
    step("restart_clears", Z);
    round_restart = 0;
    step("after_restart", Z);

    // Double KO, then reset during KO
    p1_health = 3'd0; p2_health = 3'd0;
    step("double_ko", K11);
    repeat (4) step("double_ko_hold", K11);
    rst = 0;
    #1 check_now("rst_in_ko", Z);
    p1_health = 3'd7; p2_health = 3'd7;
    #2 rst = 1;
    step("after_rst_ko", Z);

    // FSM back in RUN: p2 hits p1, then reset mid-stun
    p2_attack_active = 1; p2_overlap = 1;
    step("p1_hit_pulse", HIT1);
    repeat (5) step("p1_stun", S1);
    rst = 0;
    #1 check_now("rst_in_stun", Z);
    p2_attack_active = 0; p2_overlap = 0;
    #2 rst = 1;
    step("after_rst_stun", Z);
    step("no_glitch", Z);
    p1_attack_active = 1; p1_overlap = 1;
    step("hit_after_rst", HIT2);
    step("stun_after_rst", S2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
